// File: rtl/player_bullet_controller.sv
// player_bullet_controller: player bullet pool that spawns on fire, rises on a divided tick and retires on hit or at the screen top.
// Optional AUTO_FIRE_EN: fire acts as a level, so held fire re-spawns each time the cooldown expires.
module player_bullet_controller #(
  parameter int BULLET_COUNT   = 8,
  parameter int MOVE_DIV       = 250_000,
  parameter int BULLET_SPEED   = 4,
  parameter int COOLDOWN       = 2_500_000,
  parameter int SPAWN_X_OFFSET = 12,
  parameter int BULLET_H       = 8
) (
  input  logic                       clk25,
  input  logic                       rst_n,
  input  logic                       fire,
  input  logic [9:0]                 player_x,
  input  logic [9:0]                 player_y,
  input  logic [BULLET_COUNT-1:0]    bullet_hit,
  output logic [10*BULLET_COUNT-1:0] bullet_x_flat,
  output logic [10*BULLET_COUNT-1:0] bullet_y_flat,
  output logic [BULLET_COUNT-1:0]    bullet_active_flat
);
  localparam int TW = $clog2(MOVE_DIV + 1);
  localparam int CW = $clog2(COOLDOWN + 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(MOVE_DIV - 1);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);
  localparam logic [9:0] X_OFF = 10'(SPAWN_X_OFFSET);
  localparam logic [9:0] H = 10'(BULLET_H);
  localparam logic [9:0] SPD = 10'(BULLET_SPEED);
  logic                    fire_q;
  logic [TW-1:0]           tick_q, tick_d;
  logic [CW-1:0]           cd_q, cd_d;
  logic [BULLET_COUNT-1:0] active_q, active_d, free_oh;
  logic [9:0]              x_q [BULLET_COUNT];
  logic [9:0]              x_d [BULLET_COUNT];
  logic [9:0]              y_q [BULLET_COUNT];
  logic [9:0]              y_d [BULLET_COUNT];
  logic                    fire_req, tick, spawn;
  logic [9:0]              spawn_x, spawn_y;
`ifdef AUTO_FIRE_EN
  assign fire_req = fire;
`else
  assign fire_req = fire & ~fire_q;
`endif
  assign tick    = tick_q == TICK_MAX;
  // lowest clear bit of the registered active vector, one-hot
  assign free_oh = ~active_q & (active_q + BULLET_COUNT'(1));
  assign spawn   = fire_req && cd_q == '0 && !(&active_q);
  assign spawn_x = player_x + X_OFF;
  assign spawn_y = player_y < H ? '0 : player_y - H;
  assign tick_d  = tick ? '0 : tick_q + TW'(1);
  assign cd_d    = spawn ? CD_LOAD : (cd_q != '0 ? cd_q - CW'(1) : '0);
  always_comb begin
    for (int j = 0; j < BULLET_COUNT; j++) begin
      active_d[j] = active_q[j];
      x_d[j] = x_q[j];
      y_d[j] = y_q[j];
      if (spawn && free_oh[j]) begin
        active_d[j] = 1'b1;
        x_d[j] = spawn_x;
        y_d[j] = spawn_y;
      end else if (active_q[j] && bullet_hit[j]) begin
        active_d[j] = 1'b0;
      end else if (active_q[j] && tick) begin
        if (y_q[j] < SPD) active_d[j] = 1'b0;
        else y_d[j] = y_q[j] - SPD;
      end
    end
  end
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      fire_q   <= 1'b0;
      tick_q   <= '0;
      cd_q     <= '0;
      active_q <= '0;
      for (int j = 0; j < BULLET_COUNT; j++) begin
        x_q[j] <= '0;
        y_q[j] <= '0;
      end
    end else begin
      fire_q   <= fire;
      tick_q   <= tick_d;
      cd_q     <= cd_d;
      active_q <= active_d;
      for (int j = 0; j < BULLET_COUNT; j++) begin
        x_q[j] <= x_d[j];
        y_q[j] <= y_d[j];
      end
    end
  end
  genvar i;
  generate
    for (i = 0; i < BULLET_COUNT; i++) begin : g_flat
      assign bullet_x_flat[i*10 +: 10] = x_q[i];
      assign bullet_y_flat[i*10 +: 10] = y_q[i];
    end
  endgenerate
  assign bullet_active_flat = active_q;
endmodule
